// File: rtl/roulette_pkg.sv
// roulette_pkg: shared slot width, default credit/timing constants, state and credit-op encodings
package roulette_pkg;
    localparam int SLOT_W           = 3;
    localparam int CNT_W            = 32;
    localparam int DEF_CREDIT_W     = 10;
    localparam int DEF_INIT_CREDIT  = 100;
    localparam int DEF_BET_COST     = 10;
    localparam int DEF_PAYOUT       = 80;
    localparam int DEF_CREDIT_MAX   = 999;
    localparam int DEF_SPIN_TIMEOUT = 500_000_000;
    localparam int DEF_RESULT_HOLD  = 100_000_000;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_SHOW   = 3'd4,
        S_OVER   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;
    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_ADD  = 2'd3;
endpackage

// File: rtl/roulette_round_ctrl_credit_accum.sv
// credit_accum: registered credit balance with load, debit and add saturating at CREDIT_MAX
module credit_accum
    import roulette_pkg::*;
#(
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int CREDIT_MAX = DEF_CREDIT_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_op,
    input  logic [CREDIT_W-1:0] i_amt,
    input  logic [CREDIT_W-1:0] i_init,
    output logic [CREDIT_W-1:0] o_credit
);
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_add;
    assign w_sum    = {1'b0, r_credit} + {1'b0, i_amt};
    assign w_add    = (w_sum > (CREDIT_W+1)'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX) : w_sum[CREDIT_W-1:0];
    assign o_credit = r_credit;
    // apply the requested credit operation; debits are guarded by the caller so never underflow
    always_ff @(posedge clk) begin
        if (rst) r_credit <= i_init;
        else r_credit <= (i_op == OP_LOAD) ? i_amt :
                         (i_op == OP_SUB)  ? r_credit - i_amt :
                         (i_op == OP_ADD)  ? w_add : r_credit;
    end
endmodule

// File: rtl/roulette_round_ctrl.sv
// roulette_round_ctrl: launches spins, settles bets, tracks credit and flags game-over/spinner timeout
module roulette_round_ctrl
    import roulette_pkg::*;
#(
    parameter int CREDIT_W     = DEF_CREDIT_W,
    parameter int INIT_CREDIT  = DEF_INIT_CREDIT,
    parameter int BET_COST     = DEF_BET_COST,
    parameter int PAYOUT       = DEF_PAYOUT,
    parameter int CREDIT_MAX   = DEF_CREDIT_MAX,
    parameter int SPIN_TIMEOUT = DEF_SPIN_TIMEOUT,
    parameter int RESULT_HOLD  = DEF_RESULT_HOLD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_spin_req,
    input  logic                i_new_game,
    input  logic [SLOT_W-1:0]   i_bet_pos,
    input  logic                i_spin_done,
    input  logic [SLOT_W-1:0]   i_result_pos,
    output logic                o_start_spin,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [SLOT_W-1:0]   o_bet_latched,
    output logic [SLOT_W-1:0]   o_last_result,
    output logic                o_round_busy,
    output logic                o_win,
    output logic                o_lose,
    output logic                o_game_over,
    output logic                o_fault
);
    state_t              r_state;
    state_t              w_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [SLOT_W-1:0]   r_bet;
    logic [SLOT_W-1:0]   r_res;
    logic                r_start;
    logic                r_busy;
    logic                r_win;
    logic                r_lose;
    logic                r_over;
    logic                r_fault;
    logic                w_low;
    logic                w_match;
    logic                w_to;
    logic                w_end;
    logic [1:0]          w_op;
    logic [CREDIT_W-1:0] w_amt;
    assign w_low   = o_credit < CREDIT_W'(BET_COST);
    assign w_match = r_res == r_bet;
    assign w_to    = r_cnt == CNT_W'(SPIN_TIMEOUT - 1);
    assign w_end   = r_cnt == CNT_W'(RESULT_HOLD - 1);
    // next round state; new_game abandons whatever is in flight
    always_comb begin
        w_nxt = r_state;
        if (i_new_game) w_nxt = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:   if (i_spin_req) w_nxt = w_low ? S_OVER : S_ARM;
                S_ARM:    w_nxt = S_WAIT;
                S_WAIT:   w_nxt = i_spin_done ? S_SETTLE : w_to ? S_FAULT : S_WAIT;
                S_SETTLE: w_nxt = S_SHOW;
                S_SHOW:   if (w_end) w_nxt = w_low ? S_OVER : S_IDLE;
                default:  w_nxt = r_state;
            endcase
        end
    end
    // credit operation: debit at launch, refund on timeout, payout on match
    always_comb begin
        w_op  = i_new_game ? OP_LOAD :
                (r_state == S_ARM) ? OP_SUB :
                ((r_state == S_WAIT && !i_spin_done && w_to) || (r_state == S_SETTLE && w_match)) ? OP_ADD : OP_HOLD;
        w_amt = i_new_game ? CREDIT_W'(INIT_CREDIT) :
                (r_state == S_SETTLE) ? CREDIT_W'(PAYOUT) : CREDIT_W'(BET_COST);
    end
    // state register, shared wait/hold counter, captures and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bet   <= '0;
            r_res   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
            r_over  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (w_nxt == r_state && (r_state == S_WAIT || r_state == S_SHOW)) ? r_cnt + 1'b1 : '0;
            r_bet   <= (r_state == S_ARM) ? i_bet_pos : r_bet;
            r_res   <= (r_state == S_WAIT && i_spin_done && !i_new_game) ? i_result_pos : r_res;
            r_start <= w_nxt == S_ARM;
            r_busy  <= w_nxt inside {S_ARM, S_WAIT, S_SETTLE, S_SHOW};
            r_win   <= (w_nxt == S_SHOW) && ((r_state == S_SETTLE) ? w_match : r_win);
            r_lose  <= (w_nxt == S_SHOW) && ((r_state == S_SETTLE) ? !w_match : r_lose);
            r_over  <= w_nxt == S_OVER;
            r_fault <= w_nxt == S_FAULT;
        end
    end
    credit_accum #(
        .CREDIT_W   (CREDIT_W),
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .i_op     (w_op),
        .i_amt    (w_amt),
        .i_init   (CREDIT_W'(INIT_CREDIT)),
        .o_credit (o_credit)
    );
    assign o_start_spin  = r_start;
    assign o_bet_latched = r_bet;
    assign o_last_result = r_res;
    assign o_round_busy  = r_busy;
    assign o_win         = r_win;
    assign o_lose        = r_lose;
    assign o_game_over   = r_over;
    assign o_fault       = r_fault;
endmodule

// File: tb/tb_roulette_round_ctrl.sv
// tb_roulette_round_ctrl: directed rounds against three parameterisations of the round controller
module tb_roulette_round_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spin_req = 1'b0;
    logic       new_game = 1'b0;
    logic [2:0] bet_pos = '0;
    logic       spin_done = 1'b0;
    logic [2:0] result_pos = '0;
    logic       a_start, a_busy, a_win, a_lose, a_over, a_fault;
    logic [9:0] a_credit;
    logic [2:0] a_bet, a_res;
    logic       b_start, b_busy, b_win, b_lose, b_over, b_fault;
    logic [9:0] b_credit;
    logic [2:0] b_bet, b_res;
    logic       c_start, c_busy, c_win, c_lose, c_over, c_fault;
    logic [9:0] c_credit;
    logic [2:0] c_bet, c_res;
    int         n_tot = 0;
    int         n_bad = 0;
    logic       prev_start = 1'b0;
    int         dbl = 0;

    always #5 clk = ~clk;

    roulette_round_ctrl #(.INIT_CREDIT(100), .SPIN_TIMEOUT(32), .RESULT_HOLD(8)) u_a (
        .clk(clk), .rst(rst), .i_spin_req(spin_req), .i_new_game(new_game), .i_bet_pos(bet_pos),
        .i_spin_done(spin_done), .i_result_pos(result_pos), .o_start_spin(a_start), .o_credit(a_credit),
        .o_bet_latched(a_bet), .o_last_result(a_res), .o_round_busy(a_busy), .o_win(a_win),
        .o_lose(a_lose), .o_game_over(a_over), .o_fault(a_fault));
    roulette_round_ctrl #(.INIT_CREDIT(20), .SPIN_TIMEOUT(32), .RESULT_HOLD(8)) u_b (
        .clk(clk), .rst(rst), .i_spin_req(spin_req), .i_new_game(new_game), .i_bet_pos(bet_pos),
        .i_spin_done(spin_done), .i_result_pos(result_pos), .o_start_spin(b_start), .o_credit(b_credit),
        .o_bet_latched(b_bet), .o_last_result(b_res), .o_round_busy(b_busy), .o_win(b_win),
        .o_lose(b_lose), .o_game_over(b_over), .o_fault(b_fault));
    roulette_round_ctrl #(.INIT_CREDIT(990), .SPIN_TIMEOUT(32), .RESULT_HOLD(8)) u_c (
        .clk(clk), .rst(rst), .i_spin_req(spin_req), .i_new_game(new_game), .i_bet_pos(bet_pos),
        .i_spin_done(spin_done), .i_result_pos(result_pos), .o_start_spin(c_start), .o_credit(c_credit),
        .o_bet_latched(c_bet), .o_last_result(c_res), .o_round_busy(c_busy), .o_win(c_win),
        .o_lose(c_lose), .o_game_over(c_over), .o_fault(c_fault));

    always @(posedge clk) begin
        if (a_start && prev_start) dbl <= dbl + 1;
        prev_start <= a_start;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic launch(input logic [2:0] b);
        bet_pos  = b;
        spin_req = 1'b1;
        tick(1);
        spin_req = 1'b0;
        tick(1);
    endtask

    task automatic finish(input logic [2:0] r);
        spin_done  = 1'b1;
        result_pos = r;
        tick(1);
        spin_done = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);
        do_reset();
        chk("rst_credit", a_credit, 100);
        chk("rst_flags", {a_start, a_busy, a_win, a_lose, a_over, a_fault}, 0);
        chk("rst_bet_res", {a_bet, a_res}, 0);

        bet_pos  = 3'd3;
        spin_req = 1'b1;
        tick(1);
        spin_req = 1'b0;
        chk("arm_start", a_start, 1);
        chk("arm_credit", a_credit, 100);
        chk("arm_busy", a_busy, 1);
        tick(1);
        chk("wait_start", a_start, 0);
        chk("wait_credit", a_credit, 90);
        chk("wait_bet", a_bet, 3);
        tick(18);
        spin_done  = 1'b1;
        result_pos = 3'd3;
        tick(1);
        spin_done = 1'b0;
        chk("settle_res", a_res, 3);
        chk("settle_win", a_win, 0);
        tick(1);
        chk("show_win", a_win, 1);
        chk("show_lose", a_lose, 0);
        chk("show_credit", a_credit, 170);
        tick(7);
        chk("show_end_win", a_win, 1);
        tick(1);
        chk("idle_win", a_win, 0);
        chk("idle_busy", a_busy, 0);
        chk("idle_credit", a_credit, 170);

        do_reset();
        chk("b_rst_credit", b_credit, 20);
        launch(3'd1);
        chk("b_r1_credit", b_credit, 10);
        finish(3'd5);
        chk("b_r1_lose", {b_win, b_lose}, 1);
        tick(8);
        chk("b_r1_idle", {b_over, b_busy, b_lose}, 0);
        launch(3'd1);
        chk("b_r2_credit", b_credit, 0);
        finish(3'd5);
        chk("b_r2_lose", b_lose, 1);
        tick(7);
        chk("b_r2_over_early", b_over, 0);
        tick(1);
        chk("b_over", b_over, 1);
        chk("b_over_busy", b_busy, 0);
        spin_req = 1'b1;
        tick(1);
        spin_req = 1'b0;
        chk("b_over_nostart", b_start, 0);
        tick(1);
        chk("b_over_hold", {b_over, b_busy}, 2);
        chk("b_over_credit", b_credit, 0);
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
        chk("b_ng_credit", b_credit, 20);
        chk("b_ng_over", b_over, 0);

        do_reset();
        launch(3'd2);
        chk("to_credit", a_credit, 90);
        tick(31);
        chk("to_before", a_fault, 0);
        chk("to_before_credit", a_credit, 90);
        tick(1);
        chk("to_fault", a_fault, 1);
        chk("to_refund", a_credit, 100);
        chk("to_busy", a_busy, 0);
        spin_done  = 1'b1;
        result_pos = 3'd6;
        tick(1);
        spin_done = 1'b0;
        chk("to_late_res", a_res, 0);
        chk("to_late_fault", a_fault, 1);
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
        chk("to_ng_fault", a_fault, 0);
        chk("to_ng_credit", a_credit, 100);

        do_reset();
        chk("sat_init", c_credit, 990);
        launch(3'd4);
        chk("sat_debit", c_credit, 980);
        finish(3'd4);
        chk("sat_credit", c_credit, 999);
        chk("sat_win", c_win, 1);

        do_reset();
        spin_done  = 1'b1;
        result_pos = 3'd7;
        tick(1);
        spin_done = 1'b0;
        chk("idle_done_res", a_res, 0);
        chk("idle_done_busy", a_busy, 0);
        launch(3'd5);
        spin_req = 1'b1;
        tick(1);
        chk("wait_req_start1", a_start, 0);
        tick(1);
        spin_req = 1'b0;
        chk("wait_req_start2", a_start, 0);
        chk("wait_req_credit", a_credit, 90);
        tick(29);
        spin_done  = 1'b1;
        result_pos = 3'd5;
        tick(1);
        spin_done = 1'b0;
        chk("coinc_fault", a_fault, 0);
        chk("coinc_res", a_res, 5);
        chk("coinc_busy", a_busy, 1);
        tick(1);
        chk("coinc_win", a_win, 1);
        chk("coinc_credit", a_credit, 170);

        tick(8);
        launch(3'd1);
        chk("mid_wait_busy", a_busy, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_credit", a_credit, 100);
        chk("mid_flags", {a_start, a_busy, a_win, a_lose, a_over, a_fault}, 0);
        chk("mid_bet_res", {a_bet, a_res}, 0);
        chk("no_double_start", dbl, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
